// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with row debounce and one-shot key events
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   fila     row lines from the keypad, active-low, asynchronous to clk
//   columna  column drive, one-hot active-low
//   entrada  code of the last accepted non-'#' key, held until the next one
//   push     one-cycle pulse, new code valid on entrada
//   guardar  one-cycle pulse, '#' accepted
module keypad_scanner #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CYC = 8,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] fila,
    output logic [3:0] columna,
    output logic [3:0] entrada,
    output logic       push,
    output logic       guardar
);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state, state_n;
    logic [3:0]       fila_m, fila_s;
    logic [1:0]       col_idx, col_idx_n;
    logic [1:0]       row_lat, row_lat_n;
    logic [CNT_W-1:0] scan_cnt, scan_cnt_n;
    logic [CNT_W-1:0] db_cnt, db_cnt_n;
    logic [3:0]       columna_n, entrada_n;
    logic             push_n, guardar_n;

    logic             row_single;
    logic [1:0]       row_found;
    logic             row_stable;
    logic             row_up;
    logic [3:0]       code;

    // Code of the key at row r, column c.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_code = 4'h1;  4'h1: key_code = 4'h2;
            4'h2: key_code = 4'h3;  4'h3: key_code = 4'hA;
            4'h4: key_code = 4'h4;  4'h5: key_code = 4'h5;
            4'h6: key_code = 4'h6;  4'h7: key_code = 4'hB;
            4'h8: key_code = 4'h7;  4'h9: key_code = 4'h8;
            4'hA: key_code = 4'h9;  4'hB: key_code = 4'hC;
            4'hC: key_code = 4'hE;  4'hD: key_code = 4'h0;
            4'hE: key_code = 4'hF;  default: key_code = 4'hD;
        endcase
    endfunction

    // Only a single low row identifies a key; two or more low rows in one
    // column are ambiguous and treated like no key at all.
    always_comb begin
        row_single = 1'b0;
        row_found  = 2'd0;
        case (fila_s)
            4'b1110: begin row_single = 1'b1; row_found = 2'd0; end
            4'b1101: begin row_single = 1'b1; row_found = 2'd1; end
            4'b1011: begin row_single = 1'b1; row_found = 2'd2; end
            4'b0111: begin row_single = 1'b1; row_found = 2'd3; end
            default: begin row_single = 1'b0; row_found = 2'd0; end
        endcase
    end

    assign row_stable = (fila_s == ~(4'b0001 << row_lat));
    assign row_up     = fila_s[row_lat];
    assign code       = key_code(row_lat, col_idx);

    always_comb begin
        state_n    = state;
        col_idx_n  = col_idx;
        columna_n  = columna;
        row_lat_n  = row_lat;
        scan_cnt_n = scan_cnt;
        db_cnt_n   = db_cnt;
        entrada_n  = entrada;
        push_n     = 1'b0;
        guardar_n  = 1'b0;
        case (state)
            SCAN: begin
                if (scan_cnt >= SCAN_LAST) begin
                    scan_cnt_n = '0;
                    if (row_single) begin
                        row_lat_n = row_found;
                        db_cnt_n  = '0;
                        state_n   = DEBOUNCE;
                    end else begin
                        col_idx_n = col_idx + 2'd1;
                        columna_n = {columna[2:0], columna[3]};
                    end
                end else begin
                    scan_cnt_n = scan_cnt + CNT_ONE;
                end
            end
            DEBOUNCE: begin
                if (!row_stable) begin
                    state_n    = SCAN;
                    scan_cnt_n = '0;
                    col_idx_n  = col_idx + 2'd1;
                    columna_n  = {columna[2:0], columna[3]};
                end else if (db_cnt >= DB_LAST) begin
                    state_n = HELD;
                    if (code == 4'hF) begin
                        guardar_n = 1'b1;
                    end else begin
                        push_n    = 1'b1;
                        entrada_n = code;
                    end
                end else begin
                    db_cnt_n = db_cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (row_up) begin
                    db_cnt_n = '0;
                    state_n  = RELEASE;
                end
            end
            RELEASE: begin
                // A low sample here is release bounce: the key is still down.
                if (!row_up) begin
                    state_n = HELD;
                end else if (db_cnt >= DB_LAST) begin
                    state_n    = SCAN;
                    scan_cnt_n = '0;
                    col_idx_n  = col_idx + 2'd1;
                    columna_n  = {columna[2:0], columna[3]};
                end else begin
                    db_cnt_n = db_cnt + CNT_ONE;
                end
            end
            default: state_n = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fila_m   <= 4'b1111;
            fila_s   <= 4'b1111;
            state    <= SCAN;
            col_idx  <= 2'd0;
            columna  <= 4'b1110;
            row_lat  <= 2'd0;
            scan_cnt <= '0;
            db_cnt   <= '0;
            entrada  <= 4'h0;
            push     <= 1'b0;
            guardar  <= 1'b0;
        end else begin
            fila_m   <= fila;
            fila_s   <= fila_m;
            state    <= state_n;
            col_idx  <= col_idx_n;
            columna  <= columna_n;
            row_lat  <= row_lat_n;
            scan_cnt <= scan_cnt_n;
            db_cnt   <= db_cnt_n;
            entrada  <= entrada_n;
            push     <= push_n;
            guardar  <= guardar_n;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] fila;
    logic [3:0] columna;
    logic [3:0] entrada;
    logic       push;
    logic       guardar;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV    (4),
        .DEBOUNCE_CYC(8),
        .CNT_W       (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .fila   (fila),
        .columna(columna),
        .entrada(entrada),
        .push   (push),
        .guardar(guardar)
    );

    // Keypad model: bit r*4+c set means the key at row r, column c is down.
    logic [15:0] pressed;
    always_comb begin
        fila = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !columna[c]) fila[r] = 1'b0;
    end

    typedef struct packed {
        logic       guard;
        logic [3:0] code;
    } exp_t;

    typedef struct {
        int         row;
        int         col;
        int         hold;
        logic [3:0] code;
        logic       guard;
    } vec_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ev_cnt  = 0;
    logic prev_pulse = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard: every pulse pops the next expected event.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (push || guardar)) begin
            ev_cnt++;
            check("pulse_gap", {31'd0, prev_pulse}, 32'd0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: push=%0b guardar=%0b entrada=%0h, expected none at %0t",
                         push, guardar, entrada, $time);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {30'd0, push, guardar}, e.guard ? 32'd1 : 32'd2);
                check("event_entrada", {28'd0, entrada}, {28'd0, e.code});
            end
        end
        prev_pulse = !rst && (push || guardar);
    end

    task automatic wait_col(input logic [3:0] col_val, input string name);
        int n;
        n = 0;
        while (columna == col_val && n < 40) begin @(negedge clk); n++; end
        while (columna != col_val && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) check({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    vec_t       vecs[10];
    logic [3:0] last_code;
    exp_t       e;
    int         ev0, n, changes;
    logic [3:0] frozen;

    initial begin
        vecs[0] = '{1, 1, 40, 4'h5, 1'b0};
        vecs[1] = '{0, 2, 40, 4'h3, 1'b0};
        vecs[2] = '{1, 1, 40, 4'h5, 1'b0};
        vecs[3] = '{2, 0, 40, 4'h7, 1'b0};
        vecs[4] = '{3, 2, 40, 4'hF, 1'b1};
        vecs[5] = '{3, 3, 40, 4'hD, 1'b0};
        vecs[6] = '{3, 1, 40, 4'h0, 1'b0};
        vecs[7] = '{3, 0, 40, 4'hE, 1'b0};
        vecs[8] = '{2, 2, 40, 4'h9, 1'b0};
        vecs[9] = '{1, 3, 40, 4'hB, 1'b0};

        rst       = 1'b1;
        pressed   = 16'h0;
        last_code = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_columna", {28'd0, columna}, 32'hE);
        check("reset_entrada", {28'd0, entrada}, 32'h0);
        check("reset_push", {31'd0, push}, 32'd0);
        check("reset_guardar", {31'd0, guardar}, 32'd0);
        repeat (10) @(negedge clk);

        // Single presses with full release; '#' keeps the previous code.
        for (int i = 0; i < 10; i++) begin
            e.guard = vecs[i].guard;
            e.code  = vecs[i].guard ? last_code : vecs[i].code;
            if (!vecs[i].guard) last_code = vecs[i].code;
            exp_q.push_back(e);
            ev0 = ev_cnt;
            pressed[vecs[i].row*4 + vecs[i].col] = 1'b1;
            repeat (vecs[i].hold) @(negedge clk);
            pressed = 16'h0;
            repeat (40) @(negedge clk);
            check("vec_events", ev_cnt - ev0, 32'd1);
            check("vec_entrada_held", {28'd0, entrada}, {28'd0, last_code});
            check("vec_queue_empty", exp_q.size(), 32'd0);
        end

        // Glitch on '8' shorter than the debounce window.
        ev0 = ev_cnt;
        wait_col(4'b1101, "glitch_wait");
        pressed[2*4+1] = 1'b1;
        repeat (5) @(negedge clk);
        pressed = 16'h0;
        n = 0;
        while (columna == 4'b1101 && n < 20) begin @(negedge clk); n++; end
        check("glitch_next_col", {28'd0, columna}, 32'hB);
        repeat (30) @(negedge clk);
        check("glitch_events", ev_cnt - ev0, 32'd0);

        // Long hold of '6' with release bounce.
        ev0 = ev_cnt;
        exp_q.push_back('{1'b0, 4'h6});
        last_code = 4'h6;
        pressed[1*4+2] = 1'b1;
        n = 0;
        while (ev_cnt == ev0 && n < 60) begin @(negedge clk); n++; end
        check("hold_detected", ev_cnt - ev0, 32'd1);
        frozen  = columna;
        check("hold_columna", {28'd0, frozen}, 32'hB);
        changes = 0;
        repeat (500) begin @(negedge clk); if (columna != frozen) changes++; end
        pressed = 16'h0;
        repeat (3) begin @(negedge clk); if (columna != frozen) changes++; end
        pressed[1*4+2] = 1'b1;
        repeat (2) begin @(negedge clk); if (columna != frozen) changes++; end
        check("hold_frozen", changes, 32'd0);
        pressed = 16'h0;
        n = 0;
        while (columna == frozen && n < 40) begin @(negedge clk); n++; end
        check("release_cycles", n, 32'd11);
        repeat (30) @(negedge clk);
        check("hold_events", ev_cnt - ev0, 32'd1);

        // '1' and '4' share column 0: ambiguous until '4' is released.
        ev0 = ev_cnt;
        pressed[0] = 1'b1;
        pressed[4] = 1'b1;
        changes = 0;
        frozen  = columna;
        repeat (40) begin
            @(negedge clk);
            if (columna != frozen) changes++;
            frozen = columna;
        end
        check("dual_rotating", {31'd0, changes >= 8}, 32'd1);
        check("dual_no_event", ev_cnt - ev0, 32'd0);
        exp_q.push_back('{1'b0, 4'h1});
        last_code = 4'h1;
        pressed[4] = 1'b0;
        repeat (40) @(negedge clk);
        pressed = 16'h0;
        repeat (40) @(negedge clk);
        check("dual_events", ev_cnt - ev0, 32'd1);
        check("dual_queue_empty", exp_q.size(), 32'd0);

        // Reset during debounce of 'A', key kept down.
        ev0 = ev_cnt;
        wait_col(4'b0111, "reset_wait");
        pressed[0*4+3] = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_columna", {28'd0, columna}, 32'hE);
        check("midrst_entrada", {28'd0, entrada}, 32'h0);
        check("midrst_push", {31'd0, push}, 32'd0);
        check("midrst_guardar", {31'd0, guardar}, 32'd0);
        exp_q.push_back('{1'b0, 4'hA});
        n = 0;
        while (!push && n < 60) begin @(negedge clk); n++; end
        check("redetect_latency", n, 32'd24);
        repeat (60) @(negedge clk);
        pressed = 16'h0;
        repeat (40) @(negedge clk);
        check("redetect_events", ev_cnt - ev0, 32'd1);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
